display_mux_n: RTL and testbench
================================

# display_mux_n

Parametrised multiplexed seven-segment display driver for the ALU board's result readout. It shows a packed hex word of DIGITS nibbles on common-anode digits, one digit per refresh slot, from a synchronous clock-enable prescaler; no derived clock is used. Compared with the fixed 4-digit scanner it adds:
- a per-frame input snapshot, so values do not tear;
- a programmable anode dead time, which removes ghosting;
- per-digit enable and decimal point;
- optional leading-zero blanking;
- a frame-start strobe.

## Interface
- DIGITS, 4: number of digits, 1..8.
- DIV, 65536: clk cycles per digit slot; must satisfy DIV ≥ BLANK+2. Counter width is $clog2(DIV).
- BLANK, 16: dead-time cycles at the start of each slot, ≥ 1.
- clk  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- num  in  4*DIGITS  packed hex value; nibble i is digit i, digit 0 rightmost.
- dp_in  in  DIGITS  per-digit decimal point request, 1 = lit.
- digit_en  in  DIGITS  per-digit enable, 1 = digit may light.
- lz_blank  in  1  1 = blank leading zeros.
- sseg  out  [0:6]  segments a..g, active-low.
- dp  out  1  decimal point, active-low.
- an  out  DIGITS  anodes, active-low; at most one bit is 0 at any time.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
**Counters**
- Slot counter cnt runs 0..DIV-1 and wraps.
- Digit index idx increments when cnt==DIV-1, wrapping from DIGITS-1 to 0.
- A frame is DIGITS×DIV cycles.

**Snapshot**
- On any cycle with idx==0 and cnt==0, the block registers num, dp_in, digit_en and lz_blank into shadow registers. This includes the first cycle after reset release.
- All display decisions for the frame use the shadow copies only. Input changes mid-frame take effect at the next frame.

**Leading-zero blanking** (shadow lz_blank=1)
- Scan digits from DIGITS-1 down to 1. A digit is LZ-blanked while its nibble is 0 and every higher digit is also LZ-blanked.
- Digit 0 is never LZ-blanked.
- An LZ-blanked digit drives sseg all off. Its anode is lit only if its shadow dp_in bit is 1, in which case only dp is shown.

**Digit lit condition:** shadow digit_en[idx]=1 AND (not LZ-blanked OR shadow dp_in[idx]=1). Disable overrides dp.

**Decode** (active-low pattern, a..g)
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000

**Output registers**
- All outputs are registered, updated from the current cnt/idx/shadow state.
- sseg and dp are loaded with digit idx's pattern while cnt < BLANK.
- an is all ones while cnt < BLANK. While cnt ≥ BLANK, an[idx] is 0 if the digit is lit.
- frame_start is registered high for the single cycle after the snapshot cycle.

## Timing
- Reset (rst=0) takes effect immediately, without waiting for clk:
  - cnt=0, idx=0, shadows=0;
  - an=all ones, sseg=1111111, dp=1, frame_start=0.
  - An assertion mid-slot blanks the display at once.
- First rising edge after release:
  - snapshot is taken, since cnt==0 and idx==0;
  - frame_start=1 after the next edge, for one cycle.
- Per slot, output-referenced (one-cycle register latency):
  - an all high for BLANK cycles, then the selected anode low for DIV-BLANK cycles;
  - segment data is valid at least BLANK cycles before its anode falls.
- frame_start period is exactly DIGITS×DIV cycles.
- idx wraps to 0 after DIGITS-1 with no skipped or extra slot; DIGITS=1 gives a slot equal to a frame.
- num is treated as a static bus: no handshake, and sampling happens only at the snapshot cycle.

## Test plan
All scenarios use DIGITS=4, DIV=8, BLANK=2.
1. **Reset:** rst=0 during activity → within the same cycle an=1111, sseg=1111111, dp=1, frame_start=0. Release → frame_start pulses once, 1 cycle later.
2. **Scan:** num=16'h12AF, digit_en=1111, lz_blank=0, dp_in=0 → an sequence 1110,1101,1011,0111, each low for 6 cycles with 2 all-high cycles between. sseg shows F=0111000, A=0001000, 2=0010010, 1=1001111. frame_start every 32 cycles.
3. **Leading-zero blanking:** lz_blank=1.
   - num=16'h0040 → digits 3 and 2 never lit; digit1=1001100, digit0=0000001.
   - num=0 → only an=1110 ever goes low.
   - num=0 with dp_in=0100 → digit2 lit with sseg=1111111, dp=0.
4. **Snapshot:** num=16'h1234, changed to 16'h5678 at cycle 10 of a frame → digits 1..3 of that frame still show 3,2,1; the next frame shows 8,7,6,5.
5. **Enable/dp:**
   - digit_en=0101, dp_in=0010 → an bits 1 and 3 never 0; dp never 0.
   - Then dp_in=0001, digit_en=1111 → dp=0 only while an=1110.
6. **Reset mid-slot:** rst=0 while an=1011 → an=1111 immediately. Release → first lit slot is digit 0, at an=1110 after 2 blank cycles.

Source files
------------

// File: rtl/display_mux_n.sv
// Multiplexed seven-segment driver for DIGITS common-anode digits.
// One digit per DIV-cycle slot; each slot opens with BLANK dead-time cycles
// (anodes off) while the segment bus settles on the new digit. Inputs are
// captured once per frame so a frame never mixes old and new values.
module display_mux_n #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 65536,
  parameter int unsigned BLANK  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*DIGITS-1:0]   num_i,
  input  logic [DIGITS-1:0]     dp_in_i,
  input  logic [DIGITS-1:0]     digit_en_i,
  input  logic                  lz_blank_i,
  output logic [0:6]            sseg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_start_o
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntMax   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(DIGITS - 1);

  // Slot and digit counters
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  // Per-frame shadow copies of the inputs
  logic [4*DIGITS-1:0] num_sh_q;
  logic [DIGITS-1:0]   dp_sh_q;
  logic [DIGITS-1:0]   en_sh_q;
  logic                lz_sh_q;

  // Registered outputs
  logic [0:6]        sseg_q, sseg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              fs_q, fs_d;

  // Decode view of the shadow state
  logic                snap;
  logic [4*DIGITS-1:0] num_eff;
  logic [DIGITS-1:0]   dp_eff;
  logic [DIGITS-1:0]   en_eff;
  logic                lz_eff;
  logic [DIGITS-1:0]   lzb;
  int unsigned         cur;
  logic [3:0]          cur_nib;
  logic                cur_lzb;
  logic                cur_en;
  logic                cur_dp;
  logic                lit;

  // Active-low a..g pattern for one hex nibble
  function automatic logic [0:6] hex_to_seg(input logic [3:0] h);
    logic [0:6] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign snap = (cnt_q == '0) && (idx_q == '0);

  // On the snapshot cycle the shadows are being loaded this very edge, so the
  // decode path sees the incoming values; otherwise it sees the held copies.
  assign num_eff = snap ? num_i      : num_sh_q;
  assign dp_eff  = snap ? dp_in_i    : dp_sh_q;
  assign en_eff  = snap ? digit_en_i : en_sh_q;
  assign lz_eff  = snap ? lz_blank_i : lz_sh_q;

  // Leading-zero chain: a digit blanks only while every digit above it did
  always_comb begin
    logic run;
    lzb = '0;
    run = lz_eff;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      run    = run & (num_eff[4*i +: 4] == 4'h0);
      lzb[i] = run;
    end
  end

  // Select the current digit and decide whether its anode may light
  always_comb begin
    cur     = 32'(idx_q);
    cur_nib = num_eff[4*cur +: 4];
    cur_lzb = lzb[cur];
    cur_en  = en_eff[cur];
    cur_dp  = dp_eff[cur];
    // A disabled digit stays dark even if its dp is requested
    lit     = cur_en & (~cur_lzb | cur_dp);
  end

  // Counter next-state: cnt wraps every slot, idx advances on the wrap
  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Output next-state: load segments during dead time, drive anode after it
  always_comb begin
    sseg_d = sseg_q;
    dp_d   = dp_q;
    an_d   = '1;
    fs_d   = snap;
    if (cnt_q < BlankEnd) begin
      sseg_d = cur_lzb ? 7'b1111111 : hex_to_seg(cur_nib);
      dp_d   = ~(cur_dp & cur_en);
    end else if (lit) begin
      an_d[cur] = 1'b0;
    end
  end

  // Counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Shadow registers, reloaded only at the frame boundary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_sh_q <= '0;
      dp_sh_q  <= '0;
      en_sh_q  <= '0;
      lz_sh_q  <= 1'b0;
    end else if (snap) begin
      num_sh_q <= num_i;
      dp_sh_q  <= dp_in_i;
      en_sh_q  <= digit_en_i;
      lz_sh_q  <= lz_blank_i;
    end
  end

  // Output registers; reset blanks the display without waiting for a clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sseg_q <= 7'b1111111;
      dp_q   <= 1'b1;
      an_q   <= '1;
      fs_q   <= 1'b0;
    end else begin
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fs_q   <= fs_d;
    end
  end

  assign sseg_o        = sseg_q;
  assign dp_o          = dp_q;
  assign an_o          = an_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_display_mux_n.sv
// Directed bench for display_mux_n (DIGITS=4, DIV=8, BLANK=2). Expected
// per-slot outputs are queued before each frame and checked cycle by cycle
// once the frame_start pulse marks the frame.
module tb_display_mux_n;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [15:0] num_i = '0;
  logic [3:0]  dp_in_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic        lz_blank_i = 1'b0;
  logic [0:6]  sseg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_start_o;

  display_mux_n #(
    .DIGITS(4),
    .DIV   (8),
    .BLANK (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .num_i        (num_i),
    .dp_in_i      (dp_in_i),
    .digit_en_i   (digit_en_i),
    .lz_blank_i   (lz_blank_i),
    .sseg_o       (sseg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] an;    // anode value while lit, 4'hF if the slot stays dark
    logic [0:6] sseg;  // checked only when the slot is lit
    logic       dp;
  } slot_t;

  slot_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [0:6] SegOff = 7'b1111111;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_slot(input logic [3:0] an, input logic [0:6] sseg, input logic dp);
    slot_t r;
    r.an   = an;
    r.sseg = sseg;
    r.dp   = dp;
    sb.push_back(r);
  endtask

  // Waits for frame_start, then checks all 32 output cycles of that frame
  // against the next four queued slots. Optionally changes num at cycle chg_k.
  task automatic check_frame(input string tag, input int chg_k, input logic [15:0] chg_num);
    slot_t      rec[4];
    int         waited;
    logic       found;
    logic [3:0] exp_an;
    waited = 0;
    found  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (sb.size() > 0) rec[s] = sb.pop_front();
    end
    while (!found && waited < 80) begin
      @(negedge clk_i);
      waited++;
      if (frame_start_o === 1'b1) found = 1'b1;
    end
    chk({tag, "_fs_seen"}, {7'b0, found}, 8'd1);
    if (!found) return;
    // frame_start must come one cycle after release or after the previous frame
    chk({tag, "_fs_period"}, 8'(waited), 8'd1);
    for (int k = 0; k < 32; k++) begin
      int s;
      int p;
      if (k > 0) @(negedge clk_i);
      s = k / 8;
      p = k % 8;
      exp_an = (p < 2) ? 4'hF : rec[s].an;
      chk($sformatf("%s_k%0d_fs", tag, k), {7'b0, frame_start_o}, {7'b0, (k == 0)});
      chk($sformatf("%s_k%0d_an", tag, k), {4'b0, an_o}, {4'b0, exp_an});
      chk($sformatf("%s_k%0d_dp", tag, k), {7'b0, dp_o}, {7'b0, rec[s].dp});
      if (rec[s].an != 4'hF) begin
        chk($sformatf("%s_k%0d_sseg", tag, k), {1'b0, sseg_o}, {1'b0, rec[s].sseg});
      end
      if (k == chg_k) num_i = chg_num;
    end
  endtask

  initial begin
    logic found;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_an",   {4'b0, an_o},          8'h0F);
    chk("rst_sseg", {1'b0, sseg_o},        8'h7F);
    chk("rst_dp",   {7'b0, dp_o},          8'd1);
    chk("rst_fs",   {7'b0, frame_start_o}, 8'd0);

    // Plain scan, two consecutive frames
    num_i = 16'h12AF; digit_en_i = 4'b1111; lz_blank_i = 1'b0; dp_in_i = 4'b0000;
    repeat (2) begin
      push_slot(4'b1110, 7'b0111000, 1'b1);
      push_slot(4'b1101, 7'b0001000, 1'b1);
      push_slot(4'b1011, 7'b0010010, 1'b1);
      push_slot(4'b0111, 7'b1001111, 1'b1);
    end
    rst_ni = 1'b1;
    check_frame("scan0", -1, 16'h0);
    check_frame("scan1", -1, 16'h0);

    // Leading-zero blanking
    lz_blank_i = 1'b1; num_i = 16'h0040;
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1101, 7'b1001100, 1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    check_frame("lz40", -1, 16'h0);

    num_i = 16'h0000;
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    check_frame("lz0", -1, 16'h0);

    dp_in_i = 4'b0100;
    push_slot(4'b1110, 7'b0000001, 1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    push_slot(4'b1011, SegOff,     1'b0);
    push_slot(4'b1111, SegOff,     1'b1);
    check_frame("lzdp", -1, 16'h0);

    // Snapshot: mid-frame change shows only in the following frame
    lz_blank_i = 1'b0; dp_in_i = 4'b0000; num_i = 16'h1234;
    push_slot(4'b1110, 7'b1001100, 1'b1);
    push_slot(4'b1101, 7'b0000110, 1'b1);
    push_slot(4'b1011, 7'b0010010, 1'b1);
    push_slot(4'b0111, 7'b1001111, 1'b1);
    push_slot(4'b1110, 7'b0000000, 1'b1);
    push_slot(4'b1101, 7'b0001111, 1'b1);
    push_slot(4'b1011, 7'b0100000, 1'b1);
    push_slot(4'b0111, 7'b0100100, 1'b1);
    check_frame("snapA", 10, 16'h5678);
    check_frame("snapB", -1, 16'h0);

    // Enable and decimal point
    num_i = 16'h8888; digit_en_i = 4'b0101; dp_in_i = 4'b0010;
    push_slot(4'b1110, 7'b0000000, 1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    push_slot(4'b1011, 7'b0000000, 1'b1);
    push_slot(4'b1111, SegOff,     1'b1);
    check_frame("en", -1, 16'h0);

    digit_en_i = 4'b1111; dp_in_i = 4'b0001;
    push_slot(4'b1110, 7'b0000000, 1'b0);
    push_slot(4'b1101, 7'b0000000, 1'b1);
    push_slot(4'b1011, 7'b0000000, 1'b1);
    push_slot(4'b0111, 7'b0000000, 1'b1);
    check_frame("dp0", -1, 16'h0);

    // Reset mid-slot while digit 2 is lit
    num_i = 16'h12AF; dp_in_i = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk_i);
      if (an_o === 4'b1011) found = 1'b1;
    end
    chk("mid_an1011_seen", {7'b0, found}, 8'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_an",   {4'b0, an_o},          8'h0F);
    chk("mid_rst_sseg", {1'b0, sseg_o},        8'h7F);
    chk("mid_rst_dp",   {7'b0, dp_o},          8'd1);
    chk("mid_rst_fs",   {7'b0, frame_start_o}, 8'd0);
    repeat (2) @(negedge clk_i);
    chk("mid_rst_hold_an", {4'b0, an_o}, 8'h0F);
    push_slot(4'b1110, 7'b0111000, 1'b1);
    push_slot(4'b1101, 7'b0001000, 1'b1);
    push_slot(4'b1011, 7'b0010010, 1'b1);
    push_slot(4'b0111, 7'b1001111, 1'b1);
    rst_ni = 1'b1;
    check_frame("rel", -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
